// File: rtl/numberle_pkg.sv
// Shared types and constants for the guess-entry path.
package numberle_pkg;

  localparam int KEY_W      = 4;
  localparam int MAX_DIGITS = 7;

  // Keypad codes that act as edit commands when keypad editing is enabled
  localparam logic [KEY_W-1:0] KEY_CLEAR = 4'hC;
  localparam logic [KEY_W-1:0] KEY_DEL   = 4'hD;
  localparam logic [KEY_W-1:0] KEY_ENTER = 4'hE;

  typedef enum logic {
    EDIT,
    SUBMIT
  } entry_state_t;

  // Decimal digit keys are 0x0..0x9
  function automatic logic is_digit(input logic [KEY_W-1:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/key_stable_filter.sv
// Turns the decoder's held key code into single press events: a sample must
// stay identical for STABLE_CYCLES comparisons before it becomes the stable
// state, and only a 0->1 transition of the stable "held" flag is a press.
module key_stable_filter
  import numberle_pkg::*;
#(
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_held,
  input  logic [KEY_W-1:0] key_code,
  output logic [KEY_W-1:0] stable_code,
  output logic             press
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [KEY_W:0]     sample_next;
  logic [KEY_W:0]     sample_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               stable_held_reg;
  logic [KEY_W-1:0]   stable_code_reg;
  logic               press_reg;

  // The code is meaningless while no key is down, so mask it to keep a
  // wandering idle code from restarting the stability count.
  assign sample_next = key_held ? {1'b1, key_code} : '0;

  // Sample, count identical samples, and latch the stable state once settled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_reg      <= '0;
      cnt_reg         <= '0;
      stable_held_reg <= 1'b0;
      stable_code_reg <= '0;
      press_reg       <= 1'b0;
    end else begin
      sample_reg <= sample_next;
      if (sample_next != sample_reg)
        cnt_reg <= '0;
      else if (cnt_reg != CNT_MAX)
        cnt_reg <= cnt_reg + 1'b1;

      press_reg <= 1'b0;
      if (cnt_reg == CNT_MAX) begin
        stable_held_reg <= sample_reg[KEY_W];
        stable_code_reg <= sample_reg[KEY_W-1:0];
        press_reg       <= sample_reg[KEY_W] & ~stable_held_reg;
      end
    end
  end

  assign stable_code = stable_code_reg;
  assign press       = press_reg;

endmodule

// File: rtl/digit_entry.sv
// Guess-entry stage: filters keypad presses, assembles DIGITS BCD digits,
// handles enter/delete buttons and hands the guess downstream via
// valid/ready. Define DIGIT_ENTRY_KEYPAD_EDIT_EN to let keypad codes 0xC/0xD/0xE
// act as clear/delete/enter.
module digit_entry
  import numberle_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_held,
  input  logic [KEY_W-1:0]    key_code,
  input  logic                btn_enter,
  input  logic                btn_del,
  input  logic                guess_ready,
  output logic                guess_valid,
  output logic [4*DIGITS-1:0] guess,
  output logic [4*DIGITS-1:0] disp_digits,
  output logic [2:0]          digit_count,
  output logic                entry_err
);

  localparam int BUF_W = 4 * DIGITS;
  localparam logic [2:0] FULL_COUNT = 3'(DIGITS);

  logic [KEY_W-1:0] stable_code;
  logic             press;

  key_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_held   (key_held),
    .key_code   (key_code),
    .stable_code(stable_code),
    .press      (press)
  );

  // Bit 0 is enter, bit 1 is delete
  logic [1:0] btn_in;
  logic [1:0] btn_edge;
  assign btn_in = {btn_del, btn_enter};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic b_reg;
    logic b_d_reg;
    // Register the level, then compare against its delayed copy for a rising edge
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        b_reg   <= 1'b0;
        b_d_reg <= 1'b0;
      end else begin
        b_reg   <= btn_in[gi];
        b_d_reg <= b_reg;
      end
    end
    assign btn_edge[gi] = b_reg & ~b_d_reg;
  end

  entry_state_t     state_reg, state_next;
  logic [BUF_W-1:0] buffer_reg, buffer_next;
  logic [BUF_W-1:0] guess_reg, guess_next;
  logic [2:0]       count_reg, count_next;
  logic             err_reg, err_next;
  logic             act_enter, act_del, act_clear, act_digit, act_bad;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= EDIT;
      buffer_reg <= '0;
      guess_reg  <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      buffer_reg <= buffer_next;
      guess_reg  <= guess_next;
      count_reg  <= count_next;
      err_reg    <= err_next;
    end
  end

  // Pick one action per cycle (enter > delete > key), then apply it
  always_comb begin
    state_next  = state_reg;
    buffer_next = buffer_reg;
    guess_next  = guess_reg;
    count_next  = count_reg;
    err_next    = 1'b0;
    act_enter   = 1'b0;
    act_del     = 1'b0;
    act_clear   = 1'b0;
    act_digit   = 1'b0;
    act_bad     = 1'b0;

    if (btn_edge[0])
      act_enter = 1'b1;
    else if (btn_edge[1])
      act_del = 1'b1;
    else if (press) begin
      if (is_digit(stable_code))
        act_digit = 1'b1;
`ifdef DIGIT_ENTRY_KEYPAD_EDIT_EN
      else if (stable_code == KEY_ENTER)
        act_enter = 1'b1;
      else if (stable_code == KEY_DEL)
        act_del = 1'b1;
      else if (stable_code == KEY_CLEAR)
        act_clear = 1'b1;
`endif
      else
        act_bad = 1'b1;
    end

    case (state_reg)
      EDIT: begin
        if (act_enter) begin
          if (count_reg == FULL_COUNT) begin
            state_next = SUBMIT;
            guess_next = buffer_reg;
          end else begin
            err_next = 1'b1;
          end
        end else if (act_del) begin
          if (count_reg != 3'd0) begin
            buffer_next = {4'h0, buffer_reg[BUF_W-1:4]};
            count_next  = count_reg - 3'd1;
          end else begin
            err_next = 1'b1;
          end
        end else if (act_clear) begin
          if (count_reg != 3'd0) begin
            buffer_next = '0;
            count_next  = 3'd0;
          end else begin
            err_next = 1'b1;
          end
        end else if (act_digit) begin
          if (count_reg != FULL_COUNT) begin
            buffer_next = {buffer_reg[BUF_W-5:0], stable_code};
            count_next  = count_reg + 3'd1;
          end else begin
            err_next = 1'b1;
          end
        end else if (act_bad) begin
          err_next = 1'b1;
        end
      end
      SUBMIT: begin
        // guess_valid is high throughout SUBMIT, so ready alone completes it
        if (guess_ready) begin
          state_next  = EDIT;
          buffer_next = '0;
          guess_next  = '0;
          count_next  = 3'd0;
        end
      end
      default: state_next = EDIT;
    endcase
  end

  assign guess_valid = (state_reg == SUBMIT);
  assign guess       = guess_reg;
  assign disp_digits = buffer_reg;
  assign digit_count = count_reg;
  assign entry_err   = err_reg;

endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry with STABLE_CYCLES=4, DIGITS=4.
module tb_digit_entry;

  localparam int DIGITS = 4;
  localparam int SC     = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                key_held;
  logic [3:0]          key_code;
  logic                btn_enter;
  logic                btn_del;
  logic                guess_ready;
  logic                guess_valid;
  logic [4*DIGITS-1:0] guess;
  logic [4*DIGITS-1:0] disp_digits;
  logic [2:0]          digit_count;
  logic                entry_err;

  int checks   = 0;
  int failures = 0;

  digit_entry #(
    .DIGITS       (DIGITS),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_held   (key_held),
    .key_code   (key_code),
    .btn_enter  (btn_enter),
    .btn_del    (btn_del),
    .guess_ready(guess_ready),
    .guess_valid(guess_valid),
    .guess      (guess),
    .disp_digits(disp_digits),
    .digit_count(digit_count),
    .entry_err  (entry_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; key_held = 1'b0; key_code = 4'h0;
    btn_enter = 1'b0; btn_del = 1'b0; guess_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Hold a key for 'hold' cycles, then release it long enough to settle
  task automatic press_key(input logic [3:0] code, input int hold);
    key_held = 1'b1; key_code = code;
    repeat (hold) tick();
    key_held = 1'b0; key_code = 4'h0;
    repeat (8) tick();
  endtask

  task automatic pulse_button(input logic enter, input logic del);
    btn_enter = enter; btn_del = del;
    tick(); tick();
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0; key_held = 1'b0; key_code = 4'h0;
    btn_enter = 1'b0; btn_del = 1'b0; guess_ready = 1'b0;
    tick(); tick();
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_disp",  32'(disp_digits), 32'h0);
    check("rst_valid", 32'(guess_valid), 32'd0);
    check("rst_err",   32'(entry_err),   32'd0);
    rst_n = 1'b1;
    tick();

    // Key 3 held 10 cycles: update lands at end of cycle 6, no repeat
    key_held = 1'b1; key_code = 4'h3;
    repeat (6) tick();
    check("k3_before_cyc6", 32'(digit_count), 32'd0);
    tick();
    check("k3_count", 32'(digit_count), 32'd1);
    check("k3_disp",  32'(disp_digits), 32'h0003);
    repeat (3) tick();
    check("k3_no_repeat", 32'(digit_count), 32'd1);
    key_held = 1'b0; key_code = 4'h0;
    repeat (8) tick();
    press_key(4'h7, 7);
    check("k7_count", 32'(digit_count), 32'd2);
    check("k7_disp",  32'(disp_digits), 32'h0037);

    // Glitching key 5 is never accepted; a clean 6-cycle hold is
    do_reset();
    for (int i = 0; i < 3; i++) begin
      key_held = 1'b1; key_code = 4'h5;
      repeat (3) tick();
      key_held = 1'b0; key_code = 4'h0;
      tick();
    end
    repeat (6) tick();
    check("glitch_count", 32'(digit_count), 32'd0);
    press_key(4'h5, 6);
    check("clean5_count", 32'(digit_count), 32'd1);
    check("clean5_disp",  32'(disp_digits), 32'h0005);

    // Full entry, submit with back-pressure, then handshake
    do_reset();
    press_key(4'h1, 7); press_key(4'h2, 7); press_key(4'h3, 7); press_key(4'h4, 7);
    check("full_disp",  32'(disp_digits), 32'h1234);
    check("full_count", 32'(digit_count), 32'd4);
    btn_enter = 1'b1;
    tick();
    check("enter_1edge_valid", 32'(guess_valid), 32'd0);
    tick();
    check("enter_2edge_valid", 32'(guess_valid), 32'd1);
    check("enter_guess",       32'(guess),       32'h1234);
    btn_enter = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid_guess", {15'd0, guess_valid, guess}, {15'd0, 1'b1, 16'h1234});
    end
    guess_ready = 1'b1;
    tick();
    check("hs_valid", 32'(guess_valid), 32'd0);
    check("hs_count", 32'(digit_count), 32'd0);
    check("hs_guess", 32'(guess),       32'h0);
    repeat (3) tick();
    check("hs_single_xfer", 32'(guess_valid), 32'd0);
    guess_ready = 1'b0;

    // Rejected actions at the boundaries
    do_reset();
    pulse_button(1'b0, 1'b1);
    check("del_empty_err", 32'(entry_err), 32'd1);
    btn_del = 1'b0;
    tick();
    check("err_one_cycle", 32'(entry_err), 32'd0);
    press_key(4'hA, 7);
    check("code_a_count", 32'(digit_count), 32'd0);
    press_key(4'h1, 7); press_key(4'h2, 7); press_key(4'h3, 7); press_key(4'h4, 7);
    key_held = 1'b1; key_code = 4'h9;
    repeat (7) tick();
    check("full_key_err",  32'(entry_err),   32'd1);
    check("full_key_disp", 32'(disp_digits), 32'h1234);
    tick();
    check("full_key_err_clr", 32'(entry_err), 32'd0);
    key_held = 1'b0; key_code = 4'h0;
    repeat (8) tick();
    pulse_button(1'b0, 1'b1);
    check("del_disp",  32'(disp_digits), 32'h0123);
    check("del_count", 32'(digit_count), 32'd3);
    btn_del = 1'b0;
    tick();
    pulse_button(1'b1, 1'b0);
    check("short_enter_err",   32'(entry_err),   32'd1);
    check("short_enter_valid", 32'(guess_valid), 32'd0);
    btn_enter = 1'b0;
    tick();

    // Enter beats delete; reset mid-SUBMIT clears everything
    do_reset();
    press_key(4'h1, 7); press_key(4'h2, 7); press_key(4'h3, 7); press_key(4'h4, 7);
    pulse_button(1'b1, 1'b1);
    check("prio_valid", 32'(guess_valid), 32'd1);
    check("prio_disp",  32'(disp_digits), 32'h1234);
    check("prio_count", 32'(digit_count), 32'd4);
    btn_enter = 1'b0; btn_del = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(guess_valid), 32'd0);
    check("midrst_guess", 32'(guess),       32'h0);
    check("midrst_disp",  32'(disp_digits), 32'h0);
    check("midrst_count", 32'(digit_count), 32'd0);
    rst_n = 1'b1;
    tick();

`ifdef DIGIT_ENTRY_KEYPAD_EDIT_EN
    // Keypad clear and enter
    do_reset();
    press_key(4'h4, 7); press_key(4'h5, 7);
    check("kp_pre_clear", 32'(digit_count), 32'd2);
    press_key(4'hC, 7);
    check("kp_clear", 32'(digit_count), 32'd0);
    press_key(4'h1, 7); press_key(4'h2, 7); press_key(4'h3, 7); press_key(4'h4, 7);
    press_key(4'hE, 7);
    check("kp_enter_valid", 32'(guess_valid), 32'd1);
    check("kp_enter_guess", 32'(guess),       32'h1234);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
